// File: rtl/cmp_sort_ctrl_if.sv
// cmp_sort_ctrl_if: input and output word streams of the sorting engine.
//   in_valid/in_data/in_ready    : unsorted words into the engine
//   out_valid/out_data/out_ready : sorted words out of the engine, smallest first
// Modports: master = stream source/sink outside the engine, slave = the engine.
interface cmp_sort_ctrl_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// checkbig: 32-bit unsigned magnitude comparator, q = a > b.
//   a, b : unsigned operands
//   q    : high when a is strictly greater than b
module checkbig (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        q
);
   assign q = a > b;
endmodule

// cmp_sort_ctrl: loads a frame of DEPTH words, bubble-sorts it in place (one compare per
// clock through a single shared checkbig), then streams it out in ascending order.
//   clk, rst    : clock, asynchronous active-high reset
//   sif         : input/output word streams (slave side)
//   busy        : high while sorting
//   sort_cycles : clocks spent in the most recent sort phase, saturating at 255
module cmp_sort_ctrl #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   cmp_sort_ctrl_if.slave   sif,
   output logic             busy,
   output logic [7:0]       sort_cycles
);
   localparam int unsigned   AW      = $clog2(DEPTH);
   localparam logic [CW-1:0] One     = CW'(1);
   localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LastJ0  = CW'(DEPTH - 2);

   typedef enum logic [1:0] {StLoad, StSort, StOut} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   wr_q, wr_d;
   logic [CW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   j_q, j_d;
   logic [CW-1:0]   pass_q, pass_d;
   logic            swapped_q, swapped_d;
   logic [7:0]      cyc_q, cyc_d;
   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     mem_d [DEPTH];

   logic [CW-1:0]   j_nxt;
   logic [CW-1:0]   last_j;
   logic            gt;
   logic            swap_any;

   assign j_nxt  = j_q + One;
   assign last_j = LastJ0 - pass_q;

   checkbig u_checkbig (
      .a (mem_q[j_q[AW-1:0]]),
      .b (mem_q[j_nxt[AW-1:0]]),
      .q (gt)
   );

   // Swap seen anywhere in the current pass, including this clock's compare.
   assign swap_any = swapped_q | gt;

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      j_d       = j_q;
      pass_d    = pass_q;
      swapped_d = swapped_q;
      cyc_d     = cyc_q;
      mem_d     = mem_q;
      unique case (state_q)
         StLoad: begin
            if (sif.in_valid) begin
               mem_d[wr_q[AW-1:0]] = sif.in_data;
               if (wr_q == LastIdx) begin
                  state_d   = StSort;
                  wr_d      = '0;
                  j_d       = '0;
                  pass_d    = '0;
                  swapped_d = 1'b0;
                  cyc_d     = '0;
               end else begin
                  wr_d = wr_q + One;
               end
            end
         end
         StSort: begin
            if (gt) begin
               mem_d[j_q[AW-1:0]]   = mem_q[j_nxt[AW-1:0]];
               mem_d[j_nxt[AW-1:0]] = mem_q[j_q[AW-1:0]];
            end
            if (cyc_q != 8'hFF) begin
               cyc_d = cyc_q + 8'd1;
            end
            if (j_q == last_j) begin
               if (!swap_any || pass_q == LastJ0) begin
                  state_d = StOut;
                  rd_d    = '0;
               end else begin
                  pass_d    = pass_q + One;
                  j_d       = '0;
                  swapped_d = 1'b0;
               end
            end else begin
               j_d       = j_nxt;
               swapped_d = swap_any;
            end
         end
         StOut: begin
            if (sif.out_ready) begin
               if (rd_q == LastIdx) begin
                  state_d = StLoad;
                  rd_d    = '0;
                  wr_d    = '0;
               end else begin
                  rd_d = rd_q + One;
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StLoad;
         wr_q      <= '0;
         rd_q      <= '0;
         j_q       <= '0;
         pass_q    <= '0;
         swapped_q <= 1'b0;
         cyc_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         j_q       <= j_d;
         pass_q    <= pass_d;
         swapped_q <= swapped_d;
         cyc_q     <= cyc_d;
         mem_q     <= mem_d;
      end
   end

   assign sif.in_ready  = (state_q == StLoad);
   assign sif.out_valid = (state_q == StOut);
   assign sif.out_data  = (state_q == StOut) ? mem_q[rd_q[AW-1:0]] : '0;
   assign busy          = (state_q == StSort);
   assign sort_cycles   = cyc_q;
endmodule
